// File: rtl/sdu_pkg.sv
// sdu_pkg: shared constants and dump-state encoding for the serial debug unit.
// ASCII constants used by the dump serialiser and the command processor echo path.
package sdu_pkg;
    typedef enum logic [2:0] {IDLE, IDX, SEP, DAT, CR, LF} dump_state_t;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h41;
endpackage

// File: rtl/sdu_hex2ascii.sv
// sdu_hex2ascii: combinational nibble to uppercase hex ASCII.
// Ports: nib (4-bit value in), asc (8-bit ASCII character out).
module sdu_hex2ascii
    import sdu_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] asc
);
    assign asc = (nib < 4'd10) ? ASC_0 + {4'h0, nib} : ASC_A + {4'h0, nib} - 8'd10;
endmodule

// File: rtl/sdu_reg_dump.sv
// sdu_reg_dump: snapshots NCH channels of DW bits and streams "IDX:VALUE\r\n" lines in hex.
// Ports: clk, rstn (async active-low), start (begin dump, IDLE only), abort (stop at byte boundary),
//        ch_data (flattened channels), d_tx/vld_tx/rdy_tx (byte handshake to UART TX),
//        busy (not IDLE), done (one-cycle pulse when the dump ends or an abort completes).
module sdu_reg_dump
    import sdu_pkg::*;
#(
    parameter int NCH  = 18,
    parameter int DW   = 32,
    parameter int IDXW = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [NCH*DW-1:0] ch_data,
    output logic [7:0]        d_tx,
    output logic              vld_tx,
    input  logic              rdy_tx,
    output logic              busy,
    output logic              done
);
    localparam int ND  = IDXW / 4;
    localparam int DD  = DW / 4;
    localparam int MX  = (ND > DD) ? ND : DD;
    localparam int DGW = (MX > 1) ? $clog2(MX) : 1;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    dump_state_t      st, n_st;
    logic [CW-1:0]    ch, n_ch;
    logic [DGW-1:0]   dig, n_dig;
    logic [NCH*DW-1:0] snap;
    logic             n_done, hs, last_dig;
    logic [IDXW-1:0]  idx_sh;
    logic [DW-1:0]    word, word_sh;
    logic [3:0]       nib;
    logic [7:0]       asc, n_byte;

    assign hs       = vld_tx & rdy_tx;
    assign last_dig = (st == IDX) ? (dig == DGW'(ND - 1)) : (dig == DGW'(DD - 1));

    always_comb begin
        n_st   = st;
        n_ch   = ch;
        n_dig  = dig;
        n_done = 1'b0;
        if (st == IDLE) begin
            if (start) begin
                n_st  = IDX;
                n_ch  = '0;
                n_dig = '0;
            end
        end else if (abort && (!vld_tx || hs)) begin
            n_st   = IDLE;
            n_done = 1'b1;
        end else if (hs) begin
            case (st)
                IDX: begin
                    n_st  = last_dig ? SEP : IDX;
                    n_dig = last_dig ? '0 : dig + 1'b1;
                end
                SEP: n_st = DAT;
                DAT: begin
                    n_st  = last_dig ? CR : DAT;
                    n_dig = last_dig ? '0 : dig + 1'b1;
                end
                CR: n_st = LF;
                LF: begin
                    if (ch == CW'(NCH - 1)) begin
                        n_st   = IDLE;
                        n_done = 1'b1;
                    end else begin
                        n_st = IDX;
                        n_ch = ch + 1'b1;
                    end
                end
                default: n_st = IDLE;
            endcase
        end
    end

    // The byte for the next state is formed here and registered, so digits are
    // picked MSB first by shifting the already-emitted nibbles off the top.
    assign word    = snap[n_ch*DW +: DW];
    assign idx_sh  = IDXW'(n_ch) << {n_dig, 2'b00};
    assign word_sh = word << {n_dig, 2'b00};
    assign nib     = (n_st == IDX) ? idx_sh[IDXW-1 -: 4] : word_sh[DW-1 -: 4];

    sdu_hex2ascii u_hex (.nib(nib), .asc(asc));

    assign n_byte = (n_st == SEP)  ? ASC_COLON :
                    (n_st == CR)   ? ASC_CR :
                    (n_st == LF)   ? ASC_LF :
                    (n_st == IDLE) ? 8'h00 : asc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st     <= IDLE;
            ch     <= '0;
            dig    <= '0;
            snap   <= '0;
            d_tx   <= 8'h00;
            vld_tx <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            st     <= n_st;
            ch     <= n_ch;
            dig    <= n_dig;
            if (st == IDLE && start)
                snap <= ch_data;
            d_tx   <= n_byte;
            vld_tx <= (n_st != IDLE);
            busy   <= (n_st != IDLE);
            done   <= n_done;
        end
    end
endmodule
